// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional ownership lock is compiled in with `define ALU_ARB_LOCK_EN.
`timescale 1ns/1ps
module alu_arbiter #(
  parameter int WIDTH   = 16,
  parameter int OPW     = 3,
  parameter bit RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req0_c,
  input  logic             req0_lock,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [WIDTH-1:0] req1_c,
  input  logic             req1_lock,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_ina,
  output logic [WIDTH-1:0] alu_inb,
  output logic [WIDTH-1:0] alu_inc,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   grant_any;
  logic   grant_id;
  logic   accept;

`ifdef ALU_ARB_LOCK_EN
  logic   lock_held;
`else
  logic   unused_lock;
  assign unused_lock = req0_lock | req1_lock;
`endif

  // Grant: the sole valid requester, or on conflict the one that did not win last.
  always_comb begin
    // NOTE: every output of this block gets a value before any condition; a path
    // that leaves one unassigned would infer a latch.
    grant_any = req0_valid | req1_valid;
    grant_id  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
`ifdef ALU_ARB_LOCK_EN
    if (lock_held) begin
      grant_id  = owner;
      grant_any = owner ? req1_valid : req0_valid;
    end
`endif
  end

  assign accept     = (state == IDLE) && grant_any;
  assign req0_ready = accept & ~grant_id;
  assign req1_ready = accept &  grant_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= ~RR_INIT;
      alu_op     <= '0;
      alu_ina    <= '0;
      alu_inb    <= '0;
      alu_inc    <= '0;
      rsp_data   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: state is updated with <= so every register samples pre-edge values.
      unique case (state)
        IDLE: begin
          // alu_* only load on accept so the ALU inputs stay quiet while idle.
          if (accept) begin
            alu_op  <= grant_id ? req1_op : req0_op;
            alu_ina <= grant_id ? req1_a  : req0_a;
            alu_inb <= grant_id ? req1_b  : req0_b;
            alu_inc <= grant_id ? req1_c  : req0_c;
            owner   <= grant_id;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_data   <= alu_out;
          rsp0_valid <= ~owner;
          rsp1_valid <=  owner;
          state      <= RESP;
        end
        RESP: begin
          if (owner ? rsp1_ready : rsp0_ready) begin
            last_grant <= owner;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_LOCK_EN
  // Lock follows the lock bit of each accepted op; an owner that goes idle
  // for a whole IDLE cycle gives it up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_held <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) lock_held <= grant_id ? req1_lock : req0_lock;
      else        lock_held <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: drivers feed op queues, a negedge monitor
// predicts grants/latency from arbitration rules and checks responses.
`timescale 1ns/1ps
module tb_alu_arbiter;
  localparam int WIDTH   = 16;
  localparam int OPW     = 3;
  localparam bit RR_INIT = 1'b0;
`ifdef ALU_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             lock;
  } op_t;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid [2];
  logic             req_ready [2];
  logic [OPW-1:0]   req_op    [2];
  logic [WIDTH-1:0] req_a     [2];
  logic [WIDTH-1:0] req_b     [2];
  logic [WIDTH-1:0] req_c     [2];
  logic             req_lock  [2];
  logic             rsp_valid [2];
  logic             rsp_ready [2];
  logic [WIDTH-1:0] rsp_data;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_ina, alu_inb, alu_inc, alu_out;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  op_t  q0 [$];
  op_t  q1 [$];
  exp_t sbq [$];
  int   grant_log [$];
  int   rsp_mode [2];
  bit   gaps;

  // Reference model state
  bit outstanding;
  int age;
  bit owner_m;
  bit last_m;
  bit lock_m;

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu_f(input logic [OPW-1:0] op,
      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return a - b;
      3'd4:    return a << b[3:0];
      3'd5:    return a + b;
      3'd6:    return c[0] ? a + b : a + 16'd1;
      default: return '0;
    endcase
  endfunction

  assign alu_out = alu_f(alu_op, alu_ina, alu_inb, alu_inc);

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .RR_INIT(RR_INIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_op(req_op[0]),
    .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_c(req_c[0]), .req0_lock(req_lock[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_op(req_op[1]),
    .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_c(req_c[1]), .req1_lock(req_lock[1]),
    .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]),
    .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]),
    .rsp_data(rsp_data), .alu_op(alu_op), .alu_ina(alu_ina), .alu_inb(alu_inb),
    .alu_inc(alu_inc), .alu_out(alu_out), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic op_t mk(input int op, input int a, input int b, input int c, input bit lk);
    op_t o;
    o.op = OPW'(op); o.a = WIDTH'(a); o.b = WIDTH'(b); o.c = WIDTH'(c); o.lock = lk;
    return o;
  endfunction

  // Driver: holds each op until the DUT accepts it, optional random gaps.
  initial begin : driver
    bit acc [2];
    int gap [2];
    op_t o;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_op[i] = '0; req_a[i] = '0; req_b[i] = '0;
      req_c[i] = '0; req_lock[i] = 1'b0; gap[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) acc[i] = rst_n && req_valid[i] && req_ready[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          req_valid[i] = 1'b0;
          gap[i] = gaps ? int'($urandom_range(0, 3)) : 0;
        end
        if (!req_valid[i]) begin
          if (gap[i] > 0) gap[i]--;
          else if ((i == 0 && q0.size() > 0) || (i == 1 && q1.size() > 0)) begin
            o = (i == 0) ? q0[0] : q1[0];
            req_valid[i] = 1'b1; req_op[i] = o.op; req_a[i] = o.a;
            req_b[i] = o.b; req_c[i] = o.c; req_lock[i] = o.lock;
          end
        end
      end
    end
  end

  initial begin : rsp_drv
    rsp_ready[0] = 1'b1; rsp_ready[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++)
        rsp_ready[i] = (rsp_mode[i] == 0) ? 1'b1 :
                       (rsp_mode[i] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor: predicts grants from round-robin/lock rules and checks every cycle.
  always @(negedge clk) begin : monitor
    logic g_any, g_id;
    exp_t e;
    if (!rst_n) begin
      outstanding = 1'b0; age = 0; owner_m = 1'b0; last_m = ~RR_INIT; lock_m = 1'b0;
      sbq.delete();
    end else begin
      if (outstanding) age++;
      g_any = 1'b0; g_id = 1'b0;
      if (!outstanding) begin
        if (LOCK_EN && lock_m) begin
          g_id = owner_m; g_any = req_valid[owner_m];
        end else if (req_valid[0] && req_valid[1]) begin
          g_any = 1'b1; g_id = ~last_m;
        end else if (req_valid[0] || req_valid[1]) begin
          g_any = 1'b1; g_id = req_valid[1];
        end
      end
      for (int i = 0; i < 2; i++)
        if (req_valid[i] && req_ready[i]) grant_log.push_back(i);
      check("req0_ready", req_ready[0], g_any && !g_id);
      check("req1_ready", req_ready[1], g_any && g_id);
      check("busy", busy, outstanding);
      check("rsp0_valid", rsp_valid[0], outstanding && age >= 2 && owner_m == 1'b0);
      check("rsp1_valid", rsp_valid[1], outstanding && age >= 2 && owner_m == 1'b1);
      if (outstanding) begin
        if (age >= 2) begin
          check("rsp_data", rsp_data, sbq[0].data);
          if (rsp_ready[owner_m]) begin
            void'(sbq.pop_front());
            last_m = owner_m;
            outstanding = 1'b0;
          end
        end
      end else if (g_any) begin
        e.id = g_id;
        e.data = alu_f(req_op[g_id], req_a[g_id], req_b[g_id], req_c[g_id]);
        sbq.push_back(e);
        owner_m = g_id; outstanding = 1'b1; age = 0;
        lock_m = LOCK_EN && req_lock[g_id];
      end else begin
        lock_m = 1'b0;
      end
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || outstanding || req_valid[0] || req_valid[1])
           && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 3000) begin
      n_fail++;
      $display("FAIL %s: timeout waiting for idle", tag);
    end
    @(negedge clk);
  endtask

  task automatic check_log(input string tag, input int e0, input int e1, input int e2, input int e3, input int n);
    int exp_v [4];
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
    check({tag, "_count"}, grant_log.size(), n);
    for (int i = 0; i < n && i < grant_log.size(); i++)
      check($sformatf("%s_grant%0d", tag, i), grant_log[i], exp_v[i]);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rsp0_valid"}, rsp_valid[0], 0);
    check({tag, "_rsp1_valid"}, rsp_valid[1], 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_alu_op"}, alu_op, 0);
    check({tag, "_alu_abc"}, {alu_ina | alu_inb | alu_inc}, 0);
  endtask

  initial begin : main
    int n;
    rst_n = 1'b0; gaps = 1'b0; rsp_mode[0] = 0; rsp_mode[1] = 0;
    repeat (2) @(posedge clk);
    #1 check_zero_outputs("reset");
    @(posedge clk); #2 rst_n = 1'b1;

    // Continuous conflict: grants alternate starting with RR_INIT.
    @(negedge clk);
    grant_log.delete();
    q0.push_back(mk(0, 'hF0F0, 'h0FF0, 0, 0)); q0.push_back(mk(0, 'hF0F0, 'h0FF0, 0, 0));
    q1.push_back(mk(1, 'hF0F0, 'h0FF0, 0, 0)); q1.push_back(mk(1, 'hF0F0, 'h0FF0, 0, 0));
    wait_idle("rr");
    check_log("rr", 0, 1, 0, 1, 4);

    // Single ADD, then increment/add select.
    q0.push_back(mk(5, 'h0003, 'h0004, 0, 0));
    wait_idle("add");
    q1.push_back(mk(6, 'h0010, 'h0020, 0, 0));
    q1.push_back(mk(6, 'h0010, 'h0020, 1, 0));
    wait_idle("sel");

    // Stalled response: req1 must wait for rsp0 handshake.
    rsp_mode[0] = 2;
    grant_log.delete();
    q0.push_back(mk(3, 'h1234, 'h0234, 0, 0));
    q1.push_back(mk(2, 'h00FF, 'h0F0F, 0, 0));
    n = 0;
    while (!rsp_valid[0] && n < 20) begin @(negedge clk); n++; end
    check("stall_rsp0_seen", rsp_valid[0], 1);
    repeat (5) @(negedge clk);
    rsp_mode[0] = 0;
    wait_idle("stall");
    check_log("stall", 0, 1, 0, 0, 2);

    // Reset during EXEC discards the op.
    q0.push_back(mk(5, 'h1111, 'h2222, 0, 0));
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    check("rst_busy_seen", busy, 1);
    rst_n = 1'b0;
    #1 check_zero_outputs("midrst");
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    q1.push_back(mk(4, 'h0001, 'h0004, 0, 0));
    wait_idle("postrst");

    // Lock: locked owner keeps the ALU for its next op.
    grant_log.delete();
    q0.push_back(mk(3, 'h00FF, 'h0001, 0, 1));
    q0.push_back(mk(5, 'h00FF, 'h0001, 0, 0));
    q1.push_back(mk(0, 'hAAAA, 'h0FF0, 0, 0));
    wait_idle("lock");
    if (LOCK_EN) check_log("lock", 0, 0, 1, 0, 3);
    else         check_log("lock", 0, 1, 0, 0, 3);

    // Random traffic with random response back-pressure.
    rsp_mode[0] = 1; rsp_mode[1] = 1; gaps = 1'b1;
    for (int i = 0; i < 30; i++) begin
      q0.push_back(mk($urandom_range(0, 7), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1))));
      q1.push_back(mk($urandom_range(0, 7), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1))));
    end
    wait_idle("random");
    check("sb_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
